rpp_header_stream_parser: RTL and testbench

RPP_HEADER_STREAM_PARSER -- requirements
Module: rpp_header_stream_parser

---
 rtl/rpp_header_pkg.sv | 34 +++
 rtl/rpp_crc8_step.sv | 23 ++
 rtl/rpp_header_stream_parser.sv | 123 ++++++++++++
 tb/tb_rpp_header_stream_parser.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpp_header_pkg.sv
// Shared definitions for the RPP header stream parser: header layout,
// CRC-8 polynomial, FSM state type and a saturating counter helper.
package rpp_header_pkg;

    localparam int unsigned HDR_BYTES        = 18;
    localparam int unsigned ADDR_OFF         = 0;
    localparam int unsigned PKT_ID_OFF       = 4;
    localparam int unsigned ORIGIN_OFF       = 8;
    localparam int unsigned CONSENT_OFF      = 10;
    localparam int unsigned ENTROPY_OFF      = 11;
    localparam int unsigned PAYLOAD_TYPE_OFF = 12;
    localparam int unsigned FALLBACK_OFF     = 13;
    localparam int unsigned WINDOW_OFF       = 14;
    localparam int unsigned PHASE_OFF        = 16;
    localparam int unsigned CRC_OFF          = 17;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        COLLECT,
        HOLD,
        DROP
    } state_t;

    // MSB index of byte 'off' inside the packed byte store of bytes 0..CRC_OFF-1
    function automatic int byte_msb(input int unsigned off);
        return 8 * (int'(CRC_OFF) - int'(off)) - 1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rpp_crc8_step.sv
// Combinational CRC-8 (poly 0x07, MSB-first) advance over one beat of
// IN_BYTES bytes; the most significant byte of data is processed first.
module rpp_crc8_step
    import rpp_header_pkg::*;
#(
    parameter int unsigned IN_BYTES = 1
) (
    input  logic [7:0]            crc_in,
    input  logic [8*IN_BYTES-1:0] data,
    output logic [7:0]            crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int unsigned b = 0; b < IN_BYTES; b++) begin
            crc_out = crc_out ^ data[8*(IN_BYTES-b)-1 -: 8];
            for (int unsigned k = 0; k < 8; k++) begin
                crc_out = crc_out[7] ? ((crc_out << 1) ^ CRC8_POLY) : (crc_out << 1);
            end
        end
    end

endmodule

// File: rtl/rpp_header_stream_parser.sv
// Collects 18-byte RPP headers from a beat stream, checks length and CRC-8,
// and presents the parsed fields on a valid/ready output held until accepted.
module rpp_header_stream_parser
    import rpp_header_pkg::*;
#(
    parameter int unsigned IN_BYTES  = 1,
    parameter int unsigned CRC_CHECK = 1,
    parameter int unsigned WID_W     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [8*IN_BYTES-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [31:0]           m_rpp_address,
    output logic [31:0]           m_pkt_id,
    output logic [15:0]           m_origin,
    output logic [7:0]            m_consent,
    output logic [7:0]            m_entropy,
    output logic [7:0]            m_payload_type,
    output logic [7:0]            m_fallback,
    output logic [WID_W-1:0]      m_window_id,
    output logic [7:0]            m_phase,
    output logic                  m_crc_ok,
    output logic [15:0]           hdr_count,
    output logic [15:0]           crc_err_count,
    output logic [15:0]           len_err_count
);

    localparam int unsigned BEATS    = HDR_BYTES / IN_BYTES;
    localparam logic [4:0]  LAST_IDX = 5'(BEATS - 1);

    state_t               state;
    logic [4:0]           beat_idx;
    logic [7:0]           crc;
    logic [7:0]           crc_next;
    logic [8*CRC_OFF-1:0] hdr;
    logic                 crc_ok;
    int unsigned          base_off;
    logic [15:0]          window;
    logic                 window_unused;

    rpp_crc8_step #(.IN_BYTES(IN_BYTES)) u_crc (
        .crc_in (crc),
        .data   (s_data),
        .crc_out(crc_next)
    );

    assign s_ready  = (state != HOLD);
    assign base_off = 32'(beat_idx) * IN_BYTES;

    assign m_rpp_address  = hdr[byte_msb(ADDR_OFF) -: 32];
    assign m_pkt_id       = hdr[byte_msb(PKT_ID_OFF) -: 32];
    assign m_origin       = hdr[byte_msb(ORIGIN_OFF) -: 16];
    assign m_consent      = hdr[byte_msb(CONSENT_OFF) -: 8];
    assign m_entropy      = hdr[byte_msb(ENTROPY_OFF) -: 8];
    assign m_payload_type = hdr[byte_msb(PAYLOAD_TYPE_OFF) -: 8];
    assign m_fallback     = hdr[byte_msb(FALLBACK_OFF) -: 8];
    assign window         = hdr[byte_msb(WINDOW_OFF) -: 16];
    assign m_window_id    = window[WID_W-1:0];
    assign window_unused  = ^window;
    assign m_phase        = hdr[byte_msb(PHASE_OFF) -: 8];
    assign m_crc_ok       = crc_ok;

    // The CRC register runs over all 18 bytes: with init 0 and no final XOR,
    // the remainder is zero exactly when byte 17 equals the CRC of bytes 0-16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= COLLECT;
            beat_idx      <= '0;
            crc           <= '0;
            hdr           <= '0;
            m_valid       <= 1'b0;
            crc_ok        <= 1'b0;
            hdr_count     <= '0;
            crc_err_count <= '0;
            len_err_count <= '0;
        end else begin
            unique case (state)
                COLLECT: if (s_valid) begin
                    for (int unsigned k = 0; k < IN_BYTES; k++) begin
                        if (base_off + k < CRC_OFF) begin
                            hdr[byte_msb(base_off + k) -: 8] <= s_data[8*(IN_BYTES-k)-1 -: 8];
                        end
                    end
                    if (s_last || beat_idx == LAST_IDX) begin
                        beat_idx <= '0;
                        crc      <= '0;
                    end else begin
                        beat_idx <= beat_idx + 5'd1;
                        crc      <= crc_next;
                    end
                    if (beat_idx == LAST_IDX && s_last) begin
                        state     <= HOLD;
                        m_valid   <= 1'b1;
                        crc_ok    <= (CRC_CHECK == 0) || (crc_next == 8'h00);
                        hdr_count <= sat_inc(hdr_count);
                        if (CRC_CHECK != 0 && crc_next != 8'h00) begin
                            crc_err_count <= sat_inc(crc_err_count);
                        end
                    end else if (beat_idx == LAST_IDX) begin
                        state         <= DROP;
                        len_err_count <= sat_inc(len_err_count);
                    end else if (s_last) begin
                        len_err_count <= sat_inc(len_err_count);
                    end
                end
                HOLD: if (m_ready) begin
                    m_valid <= 1'b0;
                    state   <= COLLECT;
                end
                DROP: if (s_valid && s_last) begin
                    state <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_rpp_header_stream_parser.sv
// Directed/randomized bench: three parser instances (1-byte CRC on, 1-byte
// CRC off sharing the same stream, 2-byte CRC on) against a byte-array model.
module tb_rpp_header_stream_parser;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Stream shared by u1 (CRC checked) and u0 (CRC skipped)
    logic        s_valid1, s_last1, m_ready1;
    logic [7:0]  s_data1;
    logic        s_ready1, m_valid1, ok1;
    logic [31:0] addr1, pkt1;
    logic [15:0] org1, hc1, cc1, lc1;
    logic [7:0]  con1, ent1, pty1, fb1, ph1;
    logic [5:0]  wid1;
    logic        s_ready0, m_valid0, ok0;
    logic [31:0] addr0, pkt0;
    logic [15:0] org0, hc0, cc0, lc0;
    logic [7:0]  con0, ent0, pty0, fb0, ph0;
    logic [5:0]  wid0;
    // 2-byte instance
    logic        s_valid2, s_last2, m_ready2;
    logic [15:0] s_data2;
    logic        s_ready2, m_valid2, ok2;
    logic [31:0] addr2, pkt2;
    logic [15:0] org2, hc2, cc2, lc2;
    logic [7:0]  con2, ent2, pty2, fb2, ph2;
    logic [11:0] wid2;

    rpp_header_stream_parser #(.IN_BYTES(1), .CRC_CHECK(1), .WID_W(6)) u1 (
        .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
        .s_last(s_last1), .m_valid(m_valid1), .m_ready(m_ready1), .m_rpp_address(addr1),
        .m_pkt_id(pkt1), .m_origin(org1), .m_consent(con1), .m_entropy(ent1),
        .m_payload_type(pty1), .m_fallback(fb1), .m_window_id(wid1), .m_phase(ph1),
        .m_crc_ok(ok1), .hdr_count(hc1), .crc_err_count(cc1), .len_err_count(lc1));

    rpp_header_stream_parser #(.IN_BYTES(1), .CRC_CHECK(0), .WID_W(6)) u0 (
        .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready0), .s_data(s_data1),
        .s_last(s_last1), .m_valid(m_valid0), .m_ready(m_ready1), .m_rpp_address(addr0),
        .m_pkt_id(pkt0), .m_origin(org0), .m_consent(con0), .m_entropy(ent0),
        .m_payload_type(pty0), .m_fallback(fb0), .m_window_id(wid0), .m_phase(ph0),
        .m_crc_ok(ok0), .hdr_count(hc0), .crc_err_count(cc0), .len_err_count(lc0));

    rpp_header_stream_parser #(.IN_BYTES(2), .CRC_CHECK(1), .WID_W(12)) u2 (
        .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .s_last(s_last2), .m_valid(m_valid2), .m_ready(m_ready2), .m_rpp_address(addr2),
        .m_pkt_id(pkt2), .m_origin(org2), .m_consent(con2), .m_entropy(ent2),
        .m_payload_type(pty2), .m_fallback(fb2), .m_window_id(wid2), .m_phase(ph2),
        .m_crc_ok(ok2), .hdr_count(hc2), .crc_err_count(cc2), .len_err_count(lc2));

    int errors = 0;
    int checks = 0;
    int hs1 = 0;
    int hs_mark;
    int e_hdr = 0, e_crc = 0, e_len = 0;
    int e2_hdr = 0, e2_crc = 0;
    bit gaps = 1'b1;
    logic [7:0] fr [20];
    longint t0;

    always @(posedge clk) if (m_valid1 && m_ready1) hs1++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: remainder of (bytes 0..16) * x^8 modulo x^8+x^2+x+1
    function automatic logic [7:0] model_crc();
        logic [143:0] m;
        m = '0;
        for (int i = 0; i < 17; i++) m[143-8*i -: 8] = fr[i];
        for (int i = 143; i >= 8; i--) if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        return m[7:0];
    endfunction

    task automatic make_frame(input bit corrupt);
        for (int i = 0; i < 17; i++) fr[i] = 8'($urandom);
        fr[17] = model_crc();
        if (corrupt) fr[17] = fr[17] ^ 8'($urandom_range(1, 255));
        fr[18] = 8'($urandom);
        fr[19] = 8'($urandom);
    endtask

    task automatic set_ref_frame();
        logic [135:0] ref_v;
        ref_v = 136'h42500000_00000001_0010_F0_2B_01_2A_0042_00;
        for (int i = 0; i < 17; i++) fr[i] = ref_v[135-8*i -: 8];
        fr[17] = model_crc();
    endtask

    task automatic send1(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid1 = 1'b0; s_data1 = 8'($urandom); s_last1 = 1'($urandom);
                @(posedge clk); #1;
            end
            s_valid1 = 1'b1; s_data1 = fr[i]; s_last1 = last && (i == n - 1);
            begin
                int g = 0;
                @(negedge clk);
                while (!s_ready1 && g < 50) begin @(negedge clk); g++; end
                chk("s_ready1_wait", s_ready1, 1);
            end
            @(posedge clk); #1;
        end
        s_valid1 = 1'b0; s_last1 = 1'b0;
    endtask

    task automatic send2();
        for (int i = 0; i < 9; i++) begin
            s_valid2 = 1'b1; s_data2 = {fr[2*i], fr[2*i+1]}; s_last2 = (i == 8);
            begin
                int g = 0;
                @(negedge clk);
                while (!s_ready2 && g < 50) begin @(negedge clk); g++; end
                chk("s_ready2_wait", s_ready2, 1);
            end
            @(posedge clk); #1;
        end
        s_valid2 = 1'b0; s_last2 = 1'b0;
    endtask

    task automatic check_out1(input bit exp_ok);
        logic [15:0] w;
        w = {fr[14], fr[15]};
        chk("m_valid1", m_valid1, 1);
        chk("addr1", addr1, {fr[0], fr[1], fr[2], fr[3]});
        chk("pkt1", pkt1, {fr[4], fr[5], fr[6], fr[7]});
        chk("origin1", org1, {fr[8], fr[9]});
        chk("consent1", con1, fr[10]);
        chk("entropy1", ent1, fr[11]);
        chk("ptype1", pty1, fr[12]);
        chk("fallback1", fb1, fr[13]);
        chk("window1", wid1, w[5:0]);
        chk("phase1", ph1, fr[16]);
        chk("crc_ok1", ok1, exp_ok);
        chk("hdr_count1", hc1, e_hdr);
        chk("crc_err1", cc1, e_crc);
        chk("len_err1", lc1, e_len);
        chk("m_valid0", m_valid0, 1);
        chk("addr0", addr0, {fr[0], fr[1], fr[2], fr[3]});
        chk("pkt0", pkt0, {fr[4], fr[5], fr[6], fr[7]});
        chk("origin0", org0, {fr[8], fr[9]});
        chk("bytes0", {con0, ent0, pty0, fb0, ph0}, {fr[10], fr[11], fr[12], fr[13], fr[16]});
        chk("window0", wid0, w[5:0]);
        chk("crc_ok0", ok0, 1);
        chk("counts0", {hc0, cc0, lc0}, {16'(e_hdr), 16'd0, 16'(e_len)});
        @(posedge clk); #1;
        chk("ack_m_valid1", m_valid1, 0);
    endtask

    task automatic check_out2(input bit exp_ok);
        logic [15:0] w;
        w = {fr[14], fr[15]};
        chk("m_valid2", m_valid2, 1);
        chk("addr2", addr2, {fr[0], fr[1], fr[2], fr[3]});
        chk("pkt2", pkt2, {fr[4], fr[5], fr[6], fr[7]});
        chk("origin2", org2, {fr[8], fr[9]});
        chk("bytes2", {con2, ent2, pty2, fb2, ph2}, {fr[10], fr[11], fr[12], fr[13], fr[16]});
        chk("window2", wid2, w[11:0]);
        chk("crc_ok2", ok2, exp_ok);
        chk("counts2", {hc2, cc2, lc2}, {16'(e2_hdr), 16'(e2_crc), 16'd0});
    endtask

    initial begin
        rst = 1'b1;
        s_valid1 = 1'b0; s_data1 = '0; s_last1 = 1'b0; m_ready1 = 1'b1;
        s_valid2 = 1'b0; s_data2 = '0; s_last2 = 1'b0; m_ready2 = 1'b1;
        #12;
        chk("rst_m_valid1", m_valid1, 0);
        chk("rst_s_ready1", s_ready1, 1);
        chk("rst_addr1", addr1, 0);
        chk("rst_crc_ok1", ok1, 0);
        chk("rst_counts1", {hc1, cc1, lc1}, 0);
        chk("rst_s_ready0", s_ready0, 1);
        chk("rst_m_valid2", m_valid2, 0);
        chk("rst_window2", wid2, 0);
        #4 rst = 1'b0;
        #1;
        chk("post_rst_s_ready1", s_ready1, 1);
        chk("post_rst_s_ready2", s_ready2, 1);
        @(posedge clk); #1;

        // Reference frame, good CRC
        set_ref_frame(); send1(18, 1'b1); e_hdr++;
        chk("ref_addr", addr1, 32'h42500000);
        chk("ref_pkt", pkt1, 32'h00000001);
        chk("ref_origin", org1, 16'h0010);
        chk("ref_consent", con1, 8'hF0);
        chk("ref_window", wid1, 6'h02);
        chk("ref_crc_ok", ok1, 1);
        chk("ref_hdr_count", hc1, 1);
        check_out1(1'b1);

        // Reference frame, corrupted CRC byte
        set_ref_frame(); fr[17] = fr[17] ^ 8'h01; send1(18, 1'b1); e_hdr++; e_crc++;
        chk("bad_crc_ok1", ok1, 0);
        chk("bad_crc_err1", cc1, 1);
        chk("nocheck_ok0", ok0, 1);
        chk("nocheck_err0", cc0, 0);
        check_out1(1'b0);

        // Short frame, then a good one
        hs_mark = hs1;
        make_frame(1'b0); send1(10, 1'b1); e_len++;
        repeat (2) @(posedge clk); #1;
        chk("short_len_err", lc1, e_len);
        chk("short_no_out", hs1 - hs_mark, 0);
        make_frame(1'b0); send1(18, 1'b1); e_hdr++;
        check_out1(1'b1);

        // Long frame, then a bad-CRC one
        hs_mark = hs1;
        make_frame(1'b0); send1(20, 1'b1); e_len++;
        @(posedge clk); #1;
        chk("long_m_valid", m_valid1, 0);
        chk("long_no_out", hs1 - hs_mark, 0);
        chk("long_len_err", lc1, e_len);
        make_frame(1'b1); send1(18, 1'b1); e_hdr++; e_crc++;
        check_out1(1'b0);

        for (int n = 0; n < 8; n++) begin
            bit bad;
            bad = ($urandom_range(0, 2) == 0);
            make_frame(bad); send1(18, 1'b1); e_hdr++;
            if (bad) e_crc++;
            check_out1(!bad);
        end

        // Reset while holding an unaccepted header
        m_ready1 = 1'b0;
        make_frame(1'b0); send1(18, 1'b1);
        chk("hold_m_valid1", m_valid1, 1);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("rst_hold_m_valid1", m_valid1, 0);
        chk("rst_hold_counts1", {hc1, cc1, lc1}, 0);
        #3 rst = 1'b0; m_ready1 = 1'b1;
        @(posedge clk); #1;
        e_hdr = 0; e_crc = 0; e_len = 0;

        // Reset mid-frame, then one good frame
        hs_mark = hs1;
        make_frame(1'b0); send1(9, 1'b0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_hdr_count", hc1, 0);
        make_frame(1'b0); send1(18, 1'b1); e_hdr++;
        check_out1(1'b1);
        chk("midrst_one_valid", hs1 - hs_mark, 1);

        // 2-byte instance: back-pressure, restart latency, throughput
        gaps = 1'b0;
        m_ready2 = 1'b0;
        set_ref_frame(); send2(); e2_hdr++;
        for (int k = 0; k < 5; k++) begin
            chk("stall_s_ready2", s_ready2, 0);
            chk("stall_m_valid2", m_valid2, 1);
            chk("stall_window2", wid2, 12'h042);
            chk("stall_addr2", addr2, 32'h42500000);
            chk("stall_crc_ok2", ok2, 1);
            @(posedge clk); #1;
        end
        check_out2(1'b1);
        m_ready2 = 1'b1;
        @(posedge clk); #1;
        chk("release_m_valid2", m_valid2, 0);
        chk("release_s_ready2", s_ready2, 1);
        t0 = $time;
        make_frame(1'b0); send2(); e2_hdr++;
        chk("accept_latency2", 64'($time - t0), 90);
        check_out2(1'b1);
        t0 = $time;
        make_frame(1'b1); send2(); e2_hdr++; e2_crc++;
        chk("throughput2", 64'($time - t0), 100);
        check_out2(1'b0);
        for (int n = 0; n < 4; n++) begin
            bit bad;
            bad = ($urandom_range(0, 1) == 0);
            make_frame(bad); send2(); e2_hdr++;
            if (bad) e2_crc++;
            check_out2(!bad);
        end
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
